// File: rtl/prng_pkg.sv
// prng_pkg: shared PRNG state width, mode/checker enums and the generator step function
package prng_pkg;
  localparam int STATE_W = 4;
  typedef enum logic [1:0] {HOLD = 2'b00, SEED = 2'b01, SHIFT = 2'b10, LFSR = 2'b11} prng_mode_t;
  typedef enum logic [1:0] {HUNT, SYNC, LOCK} chk_state_t;
  function automatic logic [STATE_W-1:0] prng_next(input logic [STATE_W-1:0] s);
    return {s[0], s[3], s[2], s[3] ^ s[0]};
  endfunction
endpackage

// File: rtl/prng_sat_cnt.sv
// prng_sat_cnt: saturating up-counter with synchronous clear and async active-high reset
module prng_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  // count up on inc, stick at all-ones, clear wins over inc
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + CNT_W'(1);
endmodule

// File: rtl/prng_checker.sv
// prng_checker: self-synchronising serial PRNG stream checker; PRNG_CHK_STATE_OUT_EN adds EXP_STATE
module prng_checker
  import prng_pkg::*;
#(
  parameter int SYNC_LEN = 4,
  parameter int LOSS_LEN = 3,
  parameter int CNT_W    = 16
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               EN,
  input  logic               SIN,
  input  logic               CLR,
  output logic               LOCKED,
  output logic               ERR,
  output logic [CNT_W-1:0]   ERR_CNT,
  output logic [CNT_W-1:0]   BIT_CNT
`ifdef PRNG_CHK_STATE_OUT_EN
  ,
  output logic [STATE_W-1:0] EXP_STATE
`endif
);
  chk_state_t         st;
  logic [2:0]         h;
  logic [1:0]         hcnt;
  logic [STATE_W-1:0] s;
  logic [3:0]         run;
  logic [2:0]         nh;
  logic [STATE_W-1:0] seed;
  logic [STATE_W-1:0] nxt;
  logic               hit;
  logic               act;
  // nh[0] is the newest bit; seed is the generator state that emitted it
  assign nh   = {h[1:0], SIN};
  assign seed = {nh[0], nh[1], nh[2], nh[0] ^ nh[1]};
  assign nxt  = prng_next(s);
  assign hit  = SIN == nxt[3];
  assign act  = EN && !CLR && st == LOCK;
`ifdef PRNG_CHK_STATE_OUT_EN
  assign EXP_STATE = s;
`endif
  prng_sat_cnt #(.CNT_W(CNT_W)) u_err (.clk(CLK), .rst(RSTn), .inc(act && !hit), .clr(CLR), .cnt(ERR_CNT));
  prng_sat_cnt #(.CNT_W(CNT_W)) u_bit (.clk(CLK), .rst(RSTn), .inc(act), .clr(CLR), .cnt(BIT_CNT));
  // hunt/sync/lock tracker; s is zeroed whenever the FSM falls back to HUNT
  always_ff @(posedge CLK or posedge RSTn)
    if (RSTn) begin
      st <= HUNT; h <= '0; hcnt <= '0; s <= '0; run <= '0; LOCKED <= 1'b0; ERR <= 1'b0;
    end else if (CLR) begin
      st <= HUNT; h <= '0; hcnt <= '0; s <= '0; run <= '0; LOCKED <= 1'b0; ERR <= 1'b0;
    end else if (!EN) begin
      ERR <= 1'b0;
    end else begin
      ERR <= 1'b0;
      case (st)
        HUNT: begin
          h    <= nh;
          hcnt <= hcnt == 2'd2 ? hcnt : hcnt + 2'd1;
          if (hcnt == 2'd2 && seed != '0) begin
            s <= seed; run <= '0; st <= SYNC;
          end
        end
        SYNC:
          if (hit) begin
            s   <= nxt;
            run <= run == 4'(SYNC_LEN - 1) ? 4'd0 : run + 4'd1;
            if (run == 4'(SYNC_LEN - 1)) begin
              st <= LOCK; LOCKED <= 1'b1;
            end
          end else begin
            st <= HUNT; h <= '0; hcnt <= '0; s <= '0; run <= '0;
          end
        LOCK: begin
          s   <= nxt;
          run <= hit ? 4'd0 : run + 4'd1;
          ERR <= !hit;
          if (!hit && run == 4'(LOSS_LEN - 1)) begin
            st <= HUNT; LOCKED <= 1'b0; h <= '0; hcnt <= '0; s <= '0; run <= '0;
          end
        end
        default: st <= HUNT;
      endcase
    end
endmodule

// File: tb/tb_prng_checker.sv
// tb_prng_checker: scoreboard bench for prng_checker driven by hand-derived directed vectors
module tb_prng_checker;
  logic        CLK = 1'b0;
  logic        RSTn = 1'b1;
  logic        EN = 1'b0;
  logic        SIN = 1'b0;
  logic        CLR = 1'b0;
  logic        LOCKED, ERR;
  logic [15:0] ERR_CNT, BIT_CNT;
  int total = 0;
  int bad = 0;
  typedef struct {
    string nm;
    logic  l;
    logic  e;
    int    ec;
    int    bc;
  } exp_t;
  exp_t q[$];
  prng_checker dut (
    .CLK(CLK), .RSTn(RSTn), .EN(EN), .SIN(SIN), .CLR(CLR),
    .LOCKED(LOCKED), .ERR(ERR), .ERR_CNT(ERR_CNT), .BIT_CNT(BIT_CNT)
  );
  always #5 CLK = ~CLK;
  // generator from 0001 in LFSR mode emits 0,1,1 repeating
  function automatic logic gen(int k);
    return (k % 3) != 0;
  endfunction
  function automatic exp_t mk(string nm, logic l, logic e, int ec, int bc);
    exp_t x;
    x.nm = nm; x.l = l; x.e = e; x.ec = ec; x.bc = bc;
    return x;
  endfunction
  task automatic check(exp_t x);
    total++;
    if (LOCKED !== x.l || ERR !== x.e || ERR_CNT !== 16'(x.ec) || BIT_CNT !== 16'(x.bc)) begin
      bad++;
      $display("FAIL %s: got locked=%0b err=%0b err_cnt=%0d bit_cnt=%0d want locked=%0b err=%0b err_cnt=%0d bit_cnt=%0d",
               x.nm, LOCKED, ERR, ERR_CNT, BIT_CNT, x.l, x.e, x.ec, x.bc);
    end
  endtask
  task automatic step(logic en, logic sin, logic clr, exp_t x);
    @(negedge CLK);
    EN = en; SIN = sin; CLR = clr;
    @(posedge CLK);
    q.push_back(x);
  endtask
  task automatic rst_pulse(string nm);
    @(negedge CLK);
    EN = 1'b0; CLR = 1'b0;
    #1 RSTn = 1'b1;
    #1 check(mk(nm, 1'b0, 1'b0, 0, 0));
    #1 RSTn = 1'b0;
  endtask
  // monitor: outputs settle after the edge that consumed an issued vector
  always @(negedge CLK) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      check(x);
    end
  end
  initial begin
    repeat (2) @(negedge CLK);
    check(mk("reset", 1'b0, 1'b0, 0, 0));
    RSTn = 1'b0;
    for (int n = 1; n <= 20; n++)
      step(1'b1, gen(n - 1), 1'b0, mk("clean", n >= 7, 1'b0, 0, n > 7 ? n - 7 : 0));
    rst_pulse("rst_s2");
    for (int n = 1; n <= 20; n++) begin
      step(1'b1, gen(n - 1), 1'b0, mk("gaps", n >= 7, 1'b0, 0, n > 7 ? n - 7 : 0));
      for (int g = 0; g <= n % 3; g++)
        step(1'b0, !gen(n - 1), 1'b0, mk("gap_hold", n >= 7, 1'b0, 0, n > 7 ? n - 7 : 0));
    end
    rst_pulse("rst_s3");
    for (int n = 1; n <= 20; n++) begin
      step(1'b1, gen(n - 1) ^ (n == 10), 1'b0, mk("single_err", n >= 7, n == 10, n >= 10 ? 1 : 0, n > 7 ? n - 7 : 0));
      if (n == 10) step(1'b0, 1'b0, 1'b0, mk("err_drop", 1'b1, 1'b0, 1, 3));
    end
    rst_pulse("rst_s4");
    for (int n = 1; n <= 22; n++)
      step(1'b1, gen(n - 1) ^ (n >= 10 && n <= 12), 1'b0,
           mk("loss_relock", (n >= 7 && n <= 11) || n >= 19, n >= 10 && n <= 12,
              n < 10 ? 0 : (n >= 12 ? 3 : n - 9),
              n < 8 ? 0 : (n <= 12 ? n - 7 : (n < 20 ? 5 : n - 14))));
    rst_pulse("rst_s5");
    for (int n = 0; n < 20; n++) step(1'b1, 1'b0, 1'b0, mk("all_zero", 1'b0, 1'b0, 0, 0));
    for (int n = 0; n < 20; n++) step(1'b1, 1'b1, 1'b0, mk("all_one", 1'b0, 1'b0, 0, 0));
    rst_pulse("rst_s6a");
    for (int n = 1; n <= 10; n++)
      step(1'b1, gen(n - 1), 1'b0, mk("pre_async", n >= 7, 1'b0, 0, n > 7 ? n - 7 : 0));
    rst_pulse("async_rst");
    for (int n = 1; n <= 10; n++)
      step(1'b1, gen(n - 1), 1'b0, mk("pre_clr", n >= 7, 1'b0, 0, n > 7 ? n - 7 : 0));
    step(1'b1, gen(10), 1'b1, mk("clr_en", 1'b0, 1'b0, 0, 0));
    for (int n = 11; n <= 13; n++) step(1'b1, gen(n), 1'b0, mk("post_clr", 1'b0, 1'b0, 0, 0));
    repeat (2) @(negedge CLK);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
